pipe_add_sub: RTL and testbench

PIPE_ADD_SUB -- requirements
Module: pipe_add_sub

---
 rtl/adder_pkg.sv | 21 ++
 rtl/adder_slice.sv | 31 +++
 rtl/pipe_add_sub.sv | 136 +++++++++++++
 tb/tb_pipe_add_sub.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared operation encoding and saturation limits for the pipelined adder.
package adder_pkg;

  typedef enum logic [1:0] {
    OP_ADD    = 2'd0,
    OP_SUB    = 2'd1,
    OP_ADDC   = 2'd2,
    OP_SATADD = 2'd3
  } op_e;

  // Largest positive two's-complement value of a w-bit word, as a bit pattern.
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value of a w-bit word, as a bit pattern.
  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational n-bit ripple slice; also exposes the carry into its top bit
// so the final slice can derive signed overflow.
module adder_slice #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ctop
);

  localparam int N1 = N + 1;

  logic [N:0] full;

  assign full        = {1'b0, a} + {1'b0, b} + N1'(cin);
  assign {cout, sum} = full;

  generate
    if (N == 1) begin : g_one
      assign ctop = cin;
    end else begin : g_many
      logic [N-1:0] low;
      assign low  = {1'b0, a[N-2:0]} + {1'b0, b[N-2:0]} + N'(cin);
      assign ctop = low[N-1];
    end
  endgenerate

endmodule

// File: rtl/pipe_add_sub.sv
// Valid/ready pipelined add/subtract: each stage adds one W/STAGES-bit slice
// and hands its carry to the next; saturation is applied at the output.
module pipe_add_sub
  import adder_pkg::*;
#(
  parameter int W      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] z,
  output logic         carry,
  output logic         ovf
);

  generate
    if (STAGES < 1 || (W % STAGES) != 0) begin : g_bad_params
      $error("pipe_add_sub: W must be a multiple of STAGES and STAGES >= 1");
    end
  endgenerate

  localparam int SW   = W / STAGES;
  localparam int LAST = STAGES - 1;
  localparam logic [W-1:0] SLICE_MASK = W'({SW{1'b1}});
  localparam logic [W-1:0] Z_MAX      = W'(sat_max(W));
  localparam logic [W-1:0] Z_MIN      = W'(sat_min(W));

  logic [STAGES-1:0] vld_reg;
  op_e               op_reg [STAGES];
  logic [W-1:0]      x_reg  [STAGES];
  logic [W-1:0]      y_reg  [STAGES];
  logic [W-1:0]      z_reg  [STAGES];
  logic              c_reg  [STAGES];
  logic              ct_reg [STAGES];

  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  op_e               op_s   [STAGES];
  logic [W-1:0]      x_s    [STAGES];
  logic [W-1:0]      y_s    [STAGES];
  logic [W-1:0]      z_s    [STAGES];
  logic              c_s    [STAGES];
  logic [W-1:0]      z_next [STAGES];
  logic [SW-1:0]     sum    [STAGES];
  logic              co     [STAGES];
  logic              ct     [STAGES];

  op_e op_in;
  assign op_in = op_e'(op);

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_src_in
        // Subtraction is folded into the first stage as x + ~y + 1.
        assign op_s[gi] = op_in;
        assign x_s[gi]  = x;
        assign y_s[gi]  = (op_in == OP_SUB) ? ~y : y;
        assign z_s[gi]  = '0;
        assign c_s[gi]  = (op_in == OP_SUB) ? 1'b1 : ((op_in == OP_ADDC) ? cin : 1'b0);
        assign load[gi] = in_valid && in_ready;
      end else begin : g_src_prev
        assign op_s[gi] = op_reg[gi-1];
        assign x_s[gi]  = x_reg[gi-1];
        assign y_s[gi]  = y_reg[gi-1];
        assign z_s[gi]  = z_reg[gi-1];
        assign c_s[gi]  = c_reg[gi-1];
        assign load[gi] = adv[gi-1];
      end

      // A stage moves on if any later stage is empty or the output is consumed;
      // written flat so no stage's advance depends on another's.
      if (gi == LAST) begin : g_adv_last
        assign adv[gi] = vld_reg[gi] && out_ready;
      end else begin : g_adv_mid
        assign adv[gi] = vld_reg[gi] && (out_ready || !(&vld_reg[LAST:gi+1]));
      end

      adder_slice #(.N(SW)) u_slice (
        .a    (x_s[gi][gi*SW +: SW]),
        .b    (y_s[gi][gi*SW +: SW]),
        .cin  (c_s[gi]),
        .sum  (sum[gi]),
        .cout (co[gi]),
        .ctop (ct[gi])
      );

      assign z_next[gi] = (z_s[gi] & ~(SLICE_MASK << (gi * SW))) | (W'(sum[gi]) << (gi * SW));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_reg <= '0;
      for (int k = 0; k < STAGES; k++) begin
        op_reg[k] <= OP_ADD;
        x_reg[k]  <= '0;
        y_reg[k]  <= '0;
        z_reg[k]  <= '0;
        c_reg[k]  <= 1'b0;
        ct_reg[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          vld_reg[k] <= 1'b1;
          op_reg[k]  <= op_s[k];
          x_reg[k]   <= x_s[k];
          y_reg[k]   <= y_s[k];
          z_reg[k]   <= z_next[k];
          c_reg[k]   <= co[k];
          ct_reg[k]  <= ct[k];
        end else if (adv[k]) begin
          vld_reg[k] <= 1'b0;
        end
      end
    end
  end

  assign in_ready  = !vld_reg[0] || adv[0];
  assign out_valid = vld_reg[LAST];
  assign carry     = c_reg[LAST];
  assign ovf       = c_reg[LAST] ^ ct_reg[LAST];
  // On overflow both operands share a sign, so x's sign picks the clamp.
  assign z = (op_reg[LAST] == OP_SATADD && ovf) ? (x_reg[LAST][W-1] ? Z_MIN : Z_MAX)
                                                 : z_reg[LAST];

endmodule

// File: tb/tb_pipe_add_sub.sv
// Scoreboard bench for pipe_add_sub (W=8, STAGES=2): directed corner cases,
// stall/backpressure, reset mid-flight and 1000 randomized transactions.
module tb_pipe_add_sub;

  localparam int W      = 8;
  localparam int STAGES = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] z;
  logic         carry;
  logic         ovf;

  pipe_add_sub #(.W(W), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .x         (x),
    .y         (y),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .carry     (carry),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] z;
    logic       c;
    logic       v;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   nres  = 0;
  logic rand_rdy    = 1'b0;
  logic ready_force = 1'b1;

  // Reference: plain integer arithmetic on the operation's meaning.
  function automatic exp_t model(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                                 input logic ci);
    exp_t e;
    int ua, ub, sa, sbv, us, ss;
    ua  = int'(a);
    ub  = int'(b);
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    case (o)
      2'd1:    begin us = ua + (255 - ub) + 1;  ss = sa - sbv; end
      2'd2:    begin us = ua + ub + int'(ci);   ss = sa + sbv + int'(ci); end
      default: begin us = ua + ub;              ss = sa + sbv; end
    endcase
    e.z  = 8'(us);
    e.c  = (us > 255);
    e.v  = (ss > 127) || (ss < -128);
    if (o == 2'd3 && e.v) e.z = (ss > 0) ? 8'h7F : 8'h80;
    e.op = o;
    e.a  = a;
    e.b  = b;
    e.ci = ci;
    return e;
  endfunction

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic send(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b, input logic ci);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      op  = o;
      x   = a;
      y   = b;
      cin = ci;
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(model(o, a, b, ci));
        done = 1'b1;
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("[TB] FAIL send_timeout: op=%0d x=%02h y=%02h never accepted", o, a, b);
    end
  endtask

  // Sole driver of out_ready: random when rand_rdy, otherwise ready_force.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  // Monitor: pops on every consume and checks hold-stability while stalled.
  initial begin : monitor
    logic       held_v;
    logic [9:0] held;
    exp_t       e;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          tests++;
          if ({z, carry, ovf} !== held) begin
            fails++;
            $display("[TB] FAIL hold_stable: got z=%02h c=%0b v=%0b, expected z=%02h c=%0b v=%0b",
                     z, carry, ovf, held[9:2], held[1], held[0]);
          end
        end
        if (out_valid && out_ready) begin
          tests++;
          if (sb_q.size() == 0) begin
            fails++;
            $display("[TB] FAIL unexpected_result: got z=%02h c=%0b v=%0b, expected none",
                     z, carry, ovf);
          end else begin
            e = sb_q.pop_front();
            nres++;
            if ({z, carry, ovf} !== {e.z, e.c, e.v}) begin
              fails++;
              $display("[TB] FAIL result %0d op=%0d x=%02h y=%02h cin=%0b: got z=%02h c=%0b v=%0b, expected z=%02h c=%0b v=%0b",
                       nres, e.op, e.a, e.b, e.ci, z, carry, ovf, e.z, e.c, e.v);
            end else begin
              $display("[TB] txn %0d op=%0d x=%02h y=%02h cin=%0b -> z=%02h c=%0b v=%0b",
                       nres, e.op, e.a, e.b, e.ci, z, carry, ovf);
            end
          end
        end
        held_v = out_valid && !out_ready;
        held   = {z, carry, ovf};
      end
    end
  end

  initial begin : main
    in_valid = 1'b0;
    op  = 2'd0;
    x   = '0;
    y   = '0;
    cin = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_z",         int'(z),         0);
    check("reset_carry",     int'(carry),     0);
    check("reset_ovf",       int'(ovf),       0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_reset", int'(in_ready), 1);

    // Latency: valid exactly two cycles after accept
    @(posedge clk);
    send(2'd0, 8'hFF, 8'h01, 1'b0);
    idle(1);
    @(negedge clk);
    check("latency_cycle1_out_valid", int'(out_valid), 0);
    @(negedge clk);
    check("latency_cycle2_out_valid", int'(out_valid), 1);

    // Directed arithmetic corners
    send(2'd0, 8'h7F, 8'h01, 1'b0);
    send(2'd3, 8'h7F, 8'h01, 1'b0);
    send(2'd3, 8'h80, 8'hFF, 1'b0);
    send(2'd1, 8'h05, 8'h07, 1'b0);
    send(2'd1, 8'h07, 8'h05, 1'b0);
    send(2'd2, 8'h0F, 8'hF0, 1'b1);
    send(2'd2, 8'hFF, 8'h00, 1'b1);
    send(2'd0, 8'h80, 8'h80, 1'b1);
    idle(4);

    // Backpressure: fill, see in_ready drop, then drain 2,4,6 in order
    ready_force = 1'b0;
    @(posedge clk);
    send(2'd0, 8'd1, 8'd1, 1'b0);
    send(2'd0, 8'd2, 8'd2, 1'b0);
    @(posedge clk);
    #1;
    x = 8'd3;
    y = 8'd3;
    repeat (3) begin
      @(negedge clk);
      check("in_ready_when_full", int'(in_ready), 0);
    end
    ready_force = 1'b1;
    send(2'd0, 8'd3, 8'd3, 1'b0);
    idle(5);
    check("drain_after_stall", sb_q.size(), 0);

    // Reset with two transactions in flight
    ready_force = 1'b0;
    @(posedge clk);
    send(2'd0, 8'h10, 8'h20, 1'b0);
    send(2'd1, 8'h30, 8'h05, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #1;
    check("inflight_out_valid", int'(out_valid), 1);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_z",         int'(z),         0);
    check("midrst_carry",     int'(carry),     0);
    check("midrst_ovf",       int'(ovf),       0);
    sb_q.delete();
    ready_force = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_midrst", int'(in_ready), 1);
    repeat (5) begin
      @(negedge clk);
      check("no_stale_result", int'(out_valid), 0);
    end

    // Randomized traffic with random output backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      send(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    idle(1);
    rand_rdy    = 1'b0;
    ready_force = 1'b1;
    for (int t = 0; t < 300 && sb_q.size() != 0; t++) @(negedge clk);
    check("final_drain", sb_q.size(), 0);
    repeat (3) @(negedge clk);
    check("idle_out_valid", int'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
